// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, flit width and the flit type
// used by both the input queues and the output-port arbiter.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 16;
  localparam int CNT_W     = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the first set request at or after ptr,
// wrapping modulo N, wins.
module rr_arbiter #(
  parameter int N     = noc_pkg::NUM_PORTS,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  import noc_pkg::*;

  // Walk offsets from farthest to nearest so the closest requester to ptr
  // is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[wrap_add(int'(ptr), off, N)]) begin
        found = 1'b1;
        idx   = IDX_W'(wrap_add(int'(ptr), off, N));
        grant = N'(1) << wrap_add(int'(ptr), off, N);
      end
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Output port of a NoC router: round-robin pops one input queue per free
// cycle into a single-entry output register and counts delivered flits.
module outport_arbiter #(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int FLIT_W    = noc_pkg::FLIT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*FLIT_W-1:0] data_i,
  output logic [NUM_PORTS-1:0]        pop_o,
  output logic [FLIT_W-1:0]           data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [noc_pkg::CNT_W-1:0]   flit_cnt_o
);
  import noc_pkg::*;

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  slot_state_e          state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_PORTS-1:0] grant;
  logic                 found;
  logic                 slot_free;
  logic                 do_grant;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_i),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (found)
  );

  // The slot frees up in the same cycle downstream takes the held flit,
  // which is what allows one flit per cycle back-to-back.
  assign slot_free = (state == SLOT_EMPTY) || ready_i;
  assign do_grant  = slot_free && found && !rst;
  assign pop_o     = do_grant ? grant : '0;
  assign valid_o   = (state == SLOT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SLOT_EMPTY;
      data_o     <= '0;
      ptr        <= '0;
      flit_cnt_o <= '0;
    end else begin
      if (valid_o && ready_i) begin
        flit_cnt_o <= flit_cnt_o + 1'b1;
      end
      if (do_grant) begin
        state  <= SLOT_FULL;
        data_o <= data_i[grant_idx*FLIT_W +: FLIT_W];
        ptr    <= IDX_W'(wrap_add(int'(grant_idx), 1, NUM_PORTS));
      end else if (ready_i) begin
        state <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_outport_arbiter.sv
// Self-checking bench for outport_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_outport_arbiter;

  localparam int NP = 5;
  localparam int FW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    req_i = '0;
  logic [NP*FW-1:0] data_i = '0;
  logic             ready_i = 1'b0;
  logic [NP-1:0]    pop_o;
  logic [FW-1:0]    data_o;
  logic             valid_o;
  logic [15:0]      flit_cnt_o;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  outport_arbiter #(
    .NUM_PORTS (NP),
    .FLIT_W    (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .pop_o      (pop_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .flit_cnt_o (flit_cnt_o)
  );

  // Reference model: what the downstream side should see, tracked as plain
  // values (held flit, whether it is pending, next search start, accepts).
  bit          m_valid;
  logic [15:0] m_data;
  int          m_ptr;
  logic [15:0] m_cnt;

  function automatic int pick(input logic [NP-1:0] req, input int start);
    for (int i = 0; i < NP; i++) begin
      if (req[(start + i) % NP]) return (start + i) % NP;
    end
    return -1;
  endfunction

  function automatic logic [FW-1:0] flit_of(input logic [NP*FW-1:0] d, input int g);
    return d[g*FW +: FW];
  endfunction

  function automatic logic [NP-1:0] expected_pop();
    int g;
    g = pick(req_i, m_ptr);
    if (rst || (m_valid && !ready_i) || g < 0) return '0;
    return NP'(1) << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ptr   <= 0;
      m_cnt   <= '0;
    end else begin
      if (m_valid && ready_i) m_cnt <= m_cnt + 16'd1;
      if ((!m_valid || ready_i) && pick(req_i, m_ptr) >= 0) begin
        m_data  <= flit_of(data_i, pick(req_i, m_ptr));
        m_valid <= 1'b1;
        m_ptr   <= (pick(req_i, m_ptr) + 1) % NP;
      end else if (ready_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_pop",   32'(pop_o),      32'(expected_pop()));
      checkOutput("model_valid", 32'(valid_o),    32'(m_valid));
      checkOutput("model_data",  32'(data_o),     32'(m_data));
      checkOutput("model_cnt",   32'(flit_cnt_o), 32'(m_cnt));
    end
  end

  // Drive one cycle's inputs just after the edge, return at the falling edge.
  task automatic applyStimulus(input logic [NP-1:0] req, input logic [NP*FW-1:0] data,
                               input logic ready);
    @(posedge clk);
    #1;
    req_i   = req;
    data_i  = data;
    ready_i = ready;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst     = 1'b1;
    req_i   = '1;
    ready_i = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(valid_o),    32'd0);
    checkOutput("rst_data",  32'(data_o),     32'd0);
    checkOutput("rst_cnt",   32'(flit_cnt_o), 32'd0);
    checkOutput("rst_pop",   32'(pop_o),      32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_i = '0;
  endtask

  function automatic logic [NP*FW-1:0] rand_data();
    logic [NP*FW-1:0] d;
    for (int i = 0; i < NP; i++) d[i*FW +: FW] = FW'($urandom);
    return d;
  endfunction

  initial begin
    logic [NP*FW-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    req_i = 5'b10101;
    @(negedge clk);
    checkOutput("init_pop",   32'(pop_o),      32'd0);
    checkOutput("init_valid", 32'(valid_o),    32'd0);
    checkOutput("init_data",  32'(data_o),     32'd0);
    checkOutput("init_cnt",   32'(flit_cnt_o), 32'd0);
    model_on = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_i = '0;

    // Single requester on queue 2
    d = rand_data();
    d[2*FW +: FW] = 16'hA5A5;
    applyStimulus(5'b00100, d, 1'b1);
    checkOutput("single_pop0",  32'(pop_o),      32'h04);
    checkOutput("single_cnt0",  32'(flit_cnt_o), 32'd0);
    applyStimulus(5'b00100, d, 1'b1);
    checkOutput("single_data",  32'(data_o),     32'hA5A5);
    checkOutput("single_valid", 32'(valid_o),    32'd1);
    checkOutput("single_pop1",  32'(pop_o),      32'h04);
    checkOutput("single_cnt1",  32'(flit_cnt_o), 32'd0);
    applyStimulus(5'b00100, d, 1'b1);
    checkOutput("single_cnt2",  32'(flit_cnt_o), 32'd1);
    applyStimulus(5'b00100, d, 1'b1);
    checkOutput("single_cnt3",  32'(flit_cnt_o), 32'd2);

    do_reset();

    // All queues requesting: strict rotation from index 0
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'b11111, rand_data(), 1'b1);
      checkOutput($sformatf("rr_order%0d", i), 32'(pop_o), 32'(5'b00001 << (i % 5)));
    end

    do_reset();

    // Backpressure holds the flit; release grants in the same cycle
    d = rand_data();
    d[0*FW +: FW] = 16'h1234;
    d[1*FW +: FW] = 16'h5678;
    applyStimulus(5'b00001, d, 1'b1);
    checkOutput("bp_first_pop", 32'(pop_o), 32'h01);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'b00010, d, 1'b0);
      checkOutput("bp_stall_pop",   32'(pop_o),   32'h00);
      checkOutput("bp_stall_data",  32'(data_o),  32'h1234);
      checkOutput("bp_stall_valid", 32'(valid_o), 32'd1);
    end
    applyStimulus(5'b00010, d, 1'b1);
    checkOutput("bp_release_pop",  32'(pop_o),  32'h02);
    checkOutput("bp_release_data", 32'(data_o), 32'h1234);
    applyStimulus(5'b00000, d, 1'b1);
    checkOutput("bp_next_data", 32'(data_o),     32'h5678);
    checkOutput("bp_next_cnt",  32'(flit_cnt_o), 32'd1);
    applyStimulus(5'b00000, d, 1'b1);
    checkOutput("bp_drain_valid", 32'(valid_o),    32'd0);
    checkOutput("bp_drain_data",  32'(data_o),     32'h5678);
    checkOutput("bp_drain_cnt",   32'(flit_cnt_o), 32'd2);

    do_reset();

    // Pointer wrap: grant 3 leaves ptr at 4, then 00011 must pick 0, then 1
    applyStimulus(5'b01000, d, 1'b1);
    checkOutput("wrap_pre_pop", 32'(pop_o), 32'h08);
    applyStimulus(5'b00011, d, 1'b1);
    checkOutput("wrap_idx0", 32'(pop_o), 32'h01);
    applyStimulus(5'b00011, d, 1'b1);
    checkOutput("wrap_ptr1", 32'(pop_o), 32'h02);

    do_reset();

    // Randomized traffic with occasional idle requests and stalls
    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : NP'($urandom_range(1, 31));
      applyStimulus(r, rand_data(), ($urandom_range(0, 3) != 0));
      if (i == 1500) do_reset();
    end

    do_reset();

    // Counter wrap after 65536 accepts
    for (int k = 0; k <= 65537; k++) begin
      applyStimulus(5'b00001, d, 1'b1);
      if (k == 65536) checkOutput("cnt_max",  32'(flit_cnt_o), 32'h0000FFFF);
      if (k == 65537) checkOutput("cnt_wrap", 32'(flit_cnt_o), 32'h00000000);
    end

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
